// File: rtl/mult_pkg.sv
// Shared definitions for the sequential Booth multiplier: FSM state
// encoding and the radix-2 Booth recode patterns on {Q[0], q_1}.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mult_state_t;

  // {Q[0], q_1} patterns that trigger an add or a subtract of the multiplicand
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: conditional add/subtract of the extended
// multiplicand into the upper accumulator half, then an arithmetic shift
// right of the whole {P_hi, Q, q_1} accumulator by one bit.
module booth_step
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [2*WIDTH+2:0] acc,
  input  logic [WIDTH:0]     a_ext,
  output logic [2*WIDTH+2:0] acc_next
);

  logic [WIDTH:0] p_hi;
  logic [WIDTH:0] p_sum;

  assign p_hi = acc[2*WIDTH+2:WIDTH+2];

  // Recode {Q[0], q_1} into add / subtract / hold, then shift arithmetically
  always_comb begin
    p_sum = p_hi;
    unique case (acc[1:0])
      BOOTH_ADD: p_sum = p_hi + a_ext;
      BOOTH_SUB: p_sum = p_hi - a_ext;
      default:   p_sum = p_hi;
    endcase
    acc_next = {p_sum[WIDTH], p_sum, acc[WIDTH+1:1]};
  end

endmodule

// File: rtl/seq_booth_multiplier.sv
// Multi-cycle radix-2 Booth multiplier. Operands are extended to WIDTH+1
// bits at acceptance (sign- or zero-extended per is_signed) so one datapath
// handles both modes; WIDTH+1 Booth steps then yield the product, which is
// registered on entry to DONE and held until the next result or reset.
module seq_booth_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 2);

  mult_state_t          state;
  mult_state_t          state_nxt;
  logic                 accept;
  logic                 last_step;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH:0]       a_ext;
  logic [WIDTH:0]       a_in_ext;
  logic [WIDTH:0]       b_in_ext;
  logic [2*WIDTH+2:0]   acc;
  logic [2*WIDTH+2:0]   acc_next;

  booth_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .acc     (acc),
    .a_ext   (a_ext),
    .acc_next(acc_next)
  );

  assign a_in_ext  = is_signed ? {A[WIDTH-1], A} : {1'b0, A};
  assign b_in_ext  = is_signed ? {B[WIDTH-1], B} : {1'b0, B};
  assign last_step = (cnt == CNT_W'(WIDTH));

  assign busy = (state == CALC);
  assign done = (state == DONE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a start is honoured in IDLE and in DONE (back-to-back)
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, Booth iteration and product register.
  // The product is taken from the combinational step output on the final
  // step edge so it is valid in the same cycle that done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      a_ext   <= '0;
      acc     <= '0;
      product <= '0;
    end else if (accept) begin
      cnt   <= '0;
      a_ext <= a_in_ext;
      acc   <= {{(WIDTH+1){1'b0}}, b_in_ext, 1'b0};
    end else if (state == CALC) begin
      acc <= acc_next;
      cnt <= cnt + CNT_W'(1);
      if (last_step) product <= acc_next[2*WIDTH:1];
    end
  end

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Self-checking bench: a WIDTH=4 and a WIDTH=8 instance are exercised with
// directed corner cases and random operands against an integer reference.
module tb_seq_booth_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start4 = 1'b0, sg4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4;
  logic [7:0]  prod4;

  logic        start8 = 1'b0, sg8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [15:0] prod8;

  int nvec = 0;
  int nerr = 0;

  bit          sel8 = 1'b0;
  logic        busy_w, done_w;
  logic [15:0] prod_w;

  assign busy_w = sel8 ? busy8 : busy4;
  assign done_w = sel8 ? done8 : done4;
  assign prod_w = sel8 ? prod8 : {8'h00, prod4};

  seq_booth_multiplier #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .is_signed(sg4),
    .A(a4), .B(b4), .busy(busy4), .done(done4), .product(prod4)
  );

  seq_booth_multiplier #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .is_signed(sg8),
    .A(a8), .B(b8), .busy(busy8), .done(done8), .product(prod8)
  );

  always #5 clk = ~clk;

  // Reference: interpret operands as w-bit integers and multiply
  function automatic logic [15:0] ref_mul(input int w, input logic [7:0] a,
                                          input logic [7:0] b, input bit sgn);
    longint av, bv, r, m;
    m  = (64'sd1 << w) - 1;
    av = longint'(a) & m;
    bv = longint'(b) & m;
    if (sgn && av >= (64'sd1 << (w - 1))) av = av - (64'sd1 << w);
    if (sgn && bv >= (64'sd1 << (w - 1))) bv = bv - (64'sd1 << w);
    r = av * bv;
    r = r & ((64'sd1 << (2 * w)) - 1);
    return 16'(r);
  endfunction

  task automatic drive(input bit w8, input logic [7:0] a, input logic [7:0] b,
                       input bit sgn, input bit st);
    if (w8) begin
      a8 = a; b8 = b; sg8 = sgn; start8 = st;
    end else begin
      a4 = a[3:0]; b4 = b[3:0]; sg4 = sgn; start4 = st;
    end
  endtask

  // Issue one operation from idle; scramble inputs while busy; report result,
  // edges from acceptance to done, busy cycles, and whether done lingered.
  task automatic run_op(input bit w8, input logic [7:0] a, input logic [7:0] b,
                        input bit sgn, output logic [15:0] p, output int lat,
                        output int busyc, output bit extra_done);
    sel8 = w8;
    @(negedge clk);
    drive(w8, a, b, sgn, 1'b1);
    @(posedge clk); #1;
    lat = 1;
    busyc = 0;
    while (!done_w && lat < 40) begin
      if (busy_w) busyc++;
      drive(w8, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      @(posedge clk); #1;
      lat++;
    end
    drive(w8, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    p = prod_w;
    @(posedge clk); #1;
    extra_done = done_w;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if ({busy4, done4, prod4} !== 10'b0) begin
      nerr++;
      $display("FAIL reset4: busy=%b done=%b product=%h, want 0 0 00", busy4, done4, prod4);
    end
    nvec++;
    if ({busy8, done8, prod8} !== 18'b0) begin
      nerr++;
      $display("FAIL reset8: busy=%b done=%b product=%h, want 0 0 0000", busy8, done8, prod8);
    end
    rst = 1'b0;
  endtask

  task automatic test_signed4;
    logic [7:0]  ta [4] = '{8'h2, 8'h8, 8'h7, 8'hF};
    logic [7:0]  tb [4] = '{8'hD, 8'h8, 8'h9, 8'hF};
    logic [15:0] te [4] = '{16'h00FA, 16'h0040, 16'h00CF, 16'h0001};
    logic [15:0] p;
    int lat, busyc;
    bit xd;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b0, ta[i], tb[i], 1'b1, p, lat, busyc, xd);
      nvec++;
      if (p !== te[i] || p !== ref_mul(4, ta[i], tb[i], 1'b1)) begin
        nerr++;
        $display("FAIL signed4[%0d]: product=%h, want %h", i, p, te[i]);
      end
      nvec++;
      if (lat != 6 || busyc != 5 || xd) begin
        nerr++;
        $display("FAIL timing4[%0d]: latency=%0d busy=%0d extra_done=%0d, want 6 5 0",
                 i, lat, busyc, xd);
      end
    end
  endtask

  task automatic test_unsigned4;
    logic [15:0] p;
    int lat, busyc;
    bit xd;
    run_op(1'b0, 8'hF, 8'hF, 1'b0, p, lat, busyc, xd);
    nvec++;
    if (p !== 16'h00E1) begin
      nerr++;
      $display("FAIL unsigned4_ff: product=%h, want 00e1", p);
    end
    run_op(1'b0, 8'h0, 8'hD, 1'b0, p, lat, busyc, xd);
    nvec++;
    if (p !== 16'h0000 || lat != 6 || busyc != 5) begin
      nerr++;
      $display("FAIL unsigned4_zero: product=%h latency=%0d busy=%0d, want 0000 6 5",
               p, lat, busyc);
    end
  endtask

  task automatic test_back_to_back;
    int lat, held_bad;
    sel8 = 1'b0;
    @(negedge clk);
    drive(1'b0, 8'h8, 8'h8, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 8'h0, 8'h0, 1'b0, 1'b0);
    lat = 1;
    while (!done4 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    nvec++;
    if (!done4 || prod4 !== 8'h40) begin
      nerr++;
      $display("FAIL b2b_first: done=%b product=%h, want 1 40", done4, prod4);
    end
    drive(1'b0, 8'h3, 8'h5, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 8'hA, 8'h6, 1'b0, 1'b0);
    lat = 1;
    held_bad = 0;
    while (!done4 && lat < 40) begin
      if (prod4 !== 8'h40) held_bad++;
      a4 = 4'($urandom); b4 = 4'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    nvec++;
    if (held_bad != 0) begin
      nerr++;
      $display("FAIL b2b_hold: product changed in %0d cycles, want 0", held_bad);
    end
    nvec++;
    if (lat != 6 || prod4 !== 8'h0F) begin
      nerr++;
      $display("FAIL b2b_second: latency=%0d product=%h, want 6 0f", lat, prod4);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int seen;
    logic [15:0] p;
    int lat, busyc;
    bit xd;
    sel8 = 1'b0;
    @(negedge clk);
    drive(1'b0, 8'h7, 8'h7, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 8'h0, 8'h0, 1'b0, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    nvec++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || prod4 !== 8'h00) begin
      nerr++;
      $display("FAIL reset_mid: busy=%b done=%b product=%h, want 0 0 00", busy4, done4, prod4);
    end
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done4 || busy4) seen++;
    end
    nvec++;
    if (seen != 0) begin
      nerr++;
      $display("FAIL reset_mid_quiet: activity in %0d cycles after abort, want 0", seen);
    end
    run_op(1'b0, 8'h9, 8'h6, 1'b1, p, lat, busyc, xd);
    nvec++;
    if (p !== 16'h00D6 || lat != 6) begin
      nerr++;
      $display("FAIL reset_mid_restart: product=%h latency=%0d, want 00d6 6", p, lat);
    end
  endtask

  task automatic test_random(input bit w8, input int n);
    logic [15:0] p, e;
    logic [7:0] a, b;
    bit sgn, xd;
    int lat, busyc, w;
    w = w8 ? 8 : 4;
    for (int i = 0; i < n; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      sgn = 1'($urandom);
      if (w8 && i < 2) begin
        a = (i == 0) ? 8'h80 : 8'hFF;
        b = a;
        sgn = (i == 0);
      end
      run_op(w8, a, b, sgn, p, lat, busyc, xd);
      e = ref_mul(w, a, b, sgn);
      if (w8 && i == 0) e = 16'h4000;
      if (w8 && i == 1) e = 16'hFE01;
      nvec++;
      if (p !== e || lat != w + 2 || busyc != w + 1 || xd) begin
        nerr++;
        $display("FAIL rand%0d[%0d]: a=%h b=%h s=%0d product=%h latency=%0d busy=%0d, want %h %0d %0d",
                 w, i, a, b, sgn, p, lat, busyc, e, w + 2, w + 1);
      end
    end
  endtask

  initial begin
    test_reset;
    test_signed4;
    test_unsigned4;
    test_back_to_back;
    test_reset_mid;
    test_random(1'b0, 300);
    test_random(1'b1, 1500);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
